// File: rtl/audio_pwm_if.sv
// Audio PWM bus: enable/sample request side and PWM/status side.
//   master : drives enable, sample; observes pwm_out, frame_start, busy, state
//   slave  : the PWM engine (inverse directions)
interface audio_pwm_if #(
  parameter int unsigned PWM_WIDTH = 8
);
  logic                 enable;
  logic [PWM_WIDTH:0]   sample;
  logic                 pwm_out;
  logic                 frame_start;
  logic                 busy;
  logic [1:0]           state;

  modport master (
    output enable, sample,
    input  pwm_out, frame_start, busy, state
  );

  modport slave (
    input  enable, sample,
    output pwm_out, frame_start, busy, state
  );
endinterface

// File: rtl/audio_pwm.sv
// Audio PWM output stage with click-free soft start/stop ramps.
// Ports:
//   clk, rst_n        : system clock, asynchronous active-low reset
//   bus.enable        : request to run the audio output
//   bus.sample        : unsigned mixed level 0..2^PWM_WIDTH (clamped above)
//   bus.pwm_out       : PWM pin, high while cnt < duty and not OFF
//   bus.frame_start   : one-cycle pulse on the first cycle of each frame
//   bus.busy          : high whenever state != OFF
//   bus.state         : OFF=0, RAMP_UP=1, RUN=2, RAMP_DOWN=3
module audio_pwm #(
  parameter int unsigned PWM_WIDTH = 8,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  audio_pwm_if.slave bus
);

  localparam int unsigned PWM_MAX = 1 << PWM_WIDTH;
  localparam int unsigned MID     = PWM_MAX / 2;
  localparam int unsigned DUTY_W  = PWM_WIDTH + 1;
  localparam int unsigned PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [1:0] S_OFF       = 2'd0;
  localparam logic [1:0] S_RAMP_UP   = 2'd1;
  localparam logic [1:0] S_RUN       = 2'd2;
  localparam logic [1:0] S_RAMP_DOWN = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [PS_W-1:0]      ps_q, ps_d;
  logic [PWM_WIDTH-1:0] cnt_q, cnt_d;
  logic [DUTY_W-1:0]    duty_q, duty_d;
  logic                 fs_q, fs_d;
  logic                 pwm_q;
  logic                 busy_q;

  logic                 tick;
  logic                 boundary;
  logic                 go_down;
  logic [DUTY_W-1:0]    duty_inc;
  logic [DUTY_W-1:0]    sample_clamped;

  assign tick     = (state_q != S_OFF) && (ps_q == PS_W'(PRESCALE - 1));
  assign boundary = tick && (cnt_q == PWM_WIDTH'(PWM_MAX - 1));
  assign duty_inc = duty_q + 1'b1;
  assign sample_clamped = (bus.sample > DUTY_W'(PWM_MAX)) ? DUTY_W'(PWM_MAX) : bus.sample;

  // Next-state, counters and duty; all non-OFF decisions wait for a frame boundary.
  always_comb begin
    state_d = state_q;
    ps_d    = ps_q;
    cnt_d   = cnt_q;
    duty_d  = duty_q;
    fs_d    = 1'b0;
    go_down = 1'b0;

    if (state_q == S_OFF) begin
      if (bus.enable) begin
        state_d = S_RAMP_UP;
        ps_d    = '0;
        cnt_d   = '0;
        duty_d  = '0;
        fs_d    = 1'b1;
      end
    end else begin
      if (tick) begin
        ps_d  = '0;
        cnt_d = cnt_q + 1'b1;
      end else begin
        ps_d  = ps_q + 1'b1;
      end

      if (boundary) begin
        fs_d = 1'b1;
        case (state_q)
          S_RAMP_UP: begin
            if (bus.enable) begin
              duty_d = duty_inc;
              if (duty_inc == DUTY_W'(MID)) state_d = S_RUN;
            end else begin
              go_down = 1'b1;
            end
          end
          S_RUN: begin
            if (bus.enable) duty_d = sample_clamped;
            else            go_down = 1'b1;
          end
          S_RAMP_DOWN: begin
            if (bus.enable) state_d = S_RAMP_UP;
            else            go_down = 1'b1;
          end
          default: ;
        endcase

        // Step down one level per frame; reaching zero shuts the output off.
        if (go_down) begin
          if (duty_q <= DUTY_W'(1)) begin
            state_d = S_OFF;
          end else begin
            duty_d  = duty_q - 1'b1;
            state_d = S_RAMP_DOWN;
          end
        end
      end

      // Entering OFF: no new frame starts, so counters clear and no pulse.
      if (state_d == S_OFF) begin
        ps_d   = '0;
        cnt_d  = '0;
        duty_d = '0;
        fs_d   = 1'b0;
      end
    end
  end

  // State registers; pwm/busy are registered from next-state values so they
  // track the counters with no extra cycle of latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_OFF;
      ps_q    <= '0;
      cnt_q   <= '0;
      duty_q  <= '0;
      fs_q    <= 1'b0;
      pwm_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ps_q    <= ps_d;
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      fs_q    <= fs_d;
      pwm_q   <= (state_d != S_OFF) && ({1'b0, cnt_d} < duty_d);
      busy_q  <= (state_d != S_OFF);
    end
  end

  assign bus.pwm_out     = pwm_q;
  assign bus.frame_start = fs_q;
  assign bus.busy        = busy_q;
  assign bus.state       = state_q;

endmodule

// File: doc/audio_pwm.md
AUDIO_PWM -- requirements
Module: audio_pwm

Interface
REQ-001 The module SHALL have parameter PWM_WIDTH, default 8, the sample resolution in bits; PWM_MAX = 2^PWM_WIDTH and MID = PWM_MAX/2.
REQ-002 The module SHALL have parameter PRESCALE, default 1, the number of clk cycles per PWM tick; legal range is 1 or greater.
REQ-003 The module SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port enable, input, 1 bit: request to run the audio output.
REQ-006 The module SHALL have port sample, input, PWM_WIDTH+1 bits: the unsigned mixed level from the channel mixer; meaningful range is 0..PWM_MAX.
REQ-007 The module SHALL have port pwm_out, output, 1 bit: the PWM audio pin.
REQ-008 The module SHALL have port frame_start, output, 1 bit: a one-cycle pulse at the start of each PWM frame.
REQ-009 The module SHALL have port busy, output, 1 bit: high whenever the state is not OFF.
REQ-010 The module SHALL have port state, output, 2 bits: OFF=0, RAMP_UP=1, RUN=2, RAMP_DOWN=3.

Function
REQ-011 The module SHALL keep a prescaler (0..PRESCALE-1), a frame counter cnt (0..PWM_MAX-1) and a duty register (PWM_WIDTH+1 bits).
REQ-012 A tick SHALL occur in any non-OFF cycle where prescaler == PRESCALE-1; the prescaler wraps to 0 on a tick and increments otherwise.
REQ-013 On each tick cnt SHALL increment, wrapping from PWM_MAX-1 to 0; a tick with cnt == PWM_MAX-1 is a frame boundary.
REQ-014 pwm_out SHALL equal (state != OFF) AND (cnt < duty), compared from registered values with no added latency; duty=PWM_MAX gives constant high and duty=0 gives constant low.
REQ-015 frame_start SHALL be a registered pulse that is high for exactly one clk in the cycle where cnt becomes 0 after a frame boundary, and also in the first cycle after OFF->RAMP_UP.
REQ-016 Leaving OFF SHALL be immediate: in OFF with enable=1, the next edge sets state=RAMP_UP, cnt=0, prescaler=0, duty=0.
REQ-017 All other state transitions and duty updates SHALL occur only at frame boundaries; duty is stable for a whole frame.
REQ-018 In RAMP_UP at a boundary: if enable=1, duty <= duty+1, and when the new duty equals MID the state becomes RUN; if enable=0, the state becomes RAMP_DOWN and the RAMP_DOWN rule applies.
REQ-019 In RUN at a boundary: if enable=1, duty <= min(sample, PWM_MAX), with sample captured on that edge; if enable=0, the RAMP_DOWN rule applies.
REQ-020 RAMP_DOWN rule: if duty==0, the state becomes OFF; otherwise duty <= duty-1, and the state becomes OFF if the new duty is 0, else RAMP_DOWN.
REQ-021 In RAMP_DOWN at a boundary with enable=1, the state SHALL become RAMP_UP with duty unchanged.
REQ-022 Entering OFF SHALL clear cnt, prescaler and duty; in OFF the counters are frozen and pwm_out=0.
REQ-023 Sample changes inside a frame SHALL have no effect until the next boundary.

Reset
REQ-024 While rst_n=0, without waiting for clk, the module SHALL hold state=OFF, cnt=0, prescaler=0, duty=0, pwm_out=0, frame_start=0 and busy=0.
REQ-025 After rst_n deasserts, the first state change SHALL occur on the first clk edge with enable=1.
REQ-026 Reset asserted mid-frame SHALL abandon the frame with no ramp-down.

Verification (PWM_WIDTH=4, PRESCALE=2: PWM_MAX=16, MID=8, frame=32 clk)
REQ-027 Reset with enable=0 -> pwm_out=0, busy=0, state=0, frame_start=0; these values hold for 100 cycles.
REQ-028 enable=1 -> state=1 next cycle, frame_start pulses, and frame k (k=0..7) is high for 2k clk; after the 8th boundary state=2 and duty=8.
REQ-029 RUN, sample=5 held -> each frame is 10 clk high then 22 low; sample=16 -> 32 high; sample=20 -> clamped, 32 high; sample=0 -> 0 high.
REQ-030 RUN, duty=5, sample changed to 12 at cnt=3 -> the current frame stays 10 clk high and the next frame is 24 clk high.
REQ-031 RUN, duty=3, enable dropped mid-frame -> the next frames are high 4, then 2 clk, then state=0 and busy=0 after the third boundary; frame_start stops.
REQ-032 RUN at cnt=7, rst_n pulsed low asynchronously between clk edges -> pwm_out, busy and state are 0 immediately and stay 0 until enable.
